// File: rtl/mux_arbiter_if.sv
// mux_arbiter_if: requester, acknowledge and output handshake bundle of the arbiter
interface mux_arbiter_if #(parameter int N = 32);
  logic req_a, ack_a, req_b, ack_b;
  logic out_valid, out_owner, out_ready;
  logic [N-1:0] in_a, in_b, out_data;
  modport master (
    output req_a, in_a, req_b, in_b, out_ready,
    input  ack_a, ack_b, out_valid, out_data, out_owner
  );
  modport slave (
    input  req_a, in_a, req_b, in_b, out_ready,
    output ack_a, ack_b, out_valid, out_data, out_owner
  );
endinterface

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter feeding a one-entry output register
module mux_arbiter (
  input logic clk,
  input logic rst,
  mux_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic last;
  logic space;
  logic load;
  logic sel;
  assign space = state == EMPTY || bus.out_ready;
  assign load = !rst && space && (bus.req_a || bus.req_b);
  assign sel = (bus.req_a && bus.req_b) ? !last : bus.req_b;
  assign bus.ack_a = load && !sel;
  assign bus.ack_b = load && sel;
  assign bus.out_valid = state == FULL;
  // output register: load the granted word, otherwise drain on out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      bus.out_data <= '0;
      bus.out_owner <= 1'b0;
      last <= 1'b1;
    end else if (load) begin
      state <= FULL;
      bus.out_data <= sel ? bus.in_b : bus.in_a;
      bus.out_owner <= sel;
      last <= sel;
    end else if (bus.out_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: scenario and randomized checks of mux_arbiter against a preference-based model
module tb_mux_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic got_a, got_b, exp_a, exp_b;
  logic m_valid, m_owner, m_pref;
  logic [31:0] m_data;
  mux_arbiter_if #(.N(32)) bif ();
  mux_arbiter dut (.clk(clk), .rst(rst), .bus(bif));
  always #5 clk = ~clk;

  task automatic cycle(input logic ra, input logic [31:0] da, input logic rb,
                       input logic [31:0] db, input logic rdy, input logic r);
    logic grant, who;
    @(negedge clk);
    rst = r;
    bif.req_a = ra;
    bif.in_a = da;
    bif.req_b = rb;
    bif.in_b = db;
    bif.out_ready = rdy;
    #1;
    got_a = bif.ack_a;
    got_b = bif.ack_b;
    grant = !r && (!m_valid || rdy) && (ra || rb);
    who = (ra && rb) ? m_pref : rb;
    exp_a = grant && !who;
    exp_b = grant && who;
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_data = 0; m_owner = 0; m_pref = 0;
    end else if (grant) begin
      m_valid = 1; m_data = who ? db : da; m_owner = who; m_pref = !who;
    end else if (rdy) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 32'h5, 1, 32'h6, 1, 1);
    cycle(1, 32'h5, 1, 32'h6, 1, 1);
    checks++; if ({got_a, got_b} !== 2'b00) begin errors++; $display("FAIL reset_ack got=%b exp=00", {got_a, got_b}); end
    checks++; if ({bif.out_valid, bif.out_owner} !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", {bif.out_valid, bif.out_owner}); end
    checks++; if (bif.out_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", bif.out_data); end
  endtask

  task automatic test_single();
    cycle(1, 32'h11111111, 0, 32'h0, 1, 0);
    checks++; if ({got_a, got_b} !== 2'b10) begin errors++; $display("FAIL single_ack got=%b exp=10", {got_a, got_b}); end
    checks++; if ({bif.out_valid, bif.out_owner} !== 2'b10) begin errors++; $display("FAIL single_state got=%b exp=10", {bif.out_valid, bif.out_owner}); end
    checks++; if (bif.out_data !== 32'h11111111) begin errors++; $display("FAIL single_data got=%h exp=11111111", bif.out_data); end
    cycle(0, 32'h0, 0, 32'h0, 1, 0);
    checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", bif.out_valid); end
  endtask

  task automatic test_alternate();
    cycle(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 32'hA, 1, 32'hB, 1, 0);
      checks++; if ({got_a, got_b} !== (i % 2 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_ack[%0d] got=%b exp=%b", i, {got_a, got_b}, i % 2 ? 2'b01 : 2'b10); end
      checks++; if (bif.out_data !== (i % 2 ? 32'hB : 32'hA) || bif.out_valid !== 1'b1) begin errors++; $display("FAIL alt_data[%0d] got=%h/%b exp=%h/1", i, bif.out_data, bif.out_valid, i % 2 ? 32'hB : 32'hA); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    cycle(1, 32'h1234, 0, 0, 1, 0);
    held = 32'h1234;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 32'hBEEF, 0, 0);
      checks++; if (got_b !== 1'b0) begin errors++; $display("FAIL stall_ack[%0d] got=%b exp=0", i, got_b); end
      checks++; if (bif.out_data !== held || bif.out_valid !== 1'b1) begin errors++; $display("FAIL stall_data[%0d] got=%h/%b exp=%h/1", i, bif.out_data, bif.out_valid, held); end
    end
    cycle(0, 0, 1, 32'hBEEF, 1, 0);
    checks++; if (got_b !== 1'b1) begin errors++; $display("FAIL release_ack got=%b exp=1", got_b); end
    checks++; if ({bif.out_valid, bif.out_owner} !== 2'b11 || bif.out_data !== 32'hBEEF) begin errors++; $display("FAIL release_out got=%b/%h exp=11/beef", {bif.out_valid, bif.out_owner}, bif.out_data); end
  endtask

  task automatic test_lone_b();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 32'hB0 + i, 1, 0);
      checks++; if ({got_a, got_b} !== 2'b01) begin errors++; $display("FAIL lone_b[%0d] got=%b exp=01", i, {got_a, got_b}); end
    end
    cycle(1, 32'hA0, 1, 32'hB9, 1, 0);
    checks++; if ({got_a, got_b} !== 2'b10) begin errors++; $display("FAIL lone_tie got=%b exp=10", {got_a, got_b}); end
    checks++; if (bif.out_owner !== 1'b0 || bif.out_data !== 32'hA0) begin errors++; $display("FAIL lone_tie_out got=%b/%h exp=0/a0", bif.out_owner, bif.out_data); end
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 1, 32'h77, 0, 0);
    cycle(1, 32'h99, 0, 0, 0, 0);
    checks++; if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL mid_full got=%b exp=1", bif.out_valid); end
    cycle(1, 32'h99, 0, 0, 1, 1);
    checks++; if (got_a !== 1'b0) begin errors++; $display("FAIL mid_rst_ack got=%b exp=0", got_a); end
    checks++; if (bif.out_valid !== 1'b0 || bif.out_data !== 32'h0) begin errors++; $display("FAIL mid_rst_out got=%b/%h exp=0/0", bif.out_valid, bif.out_data); end
    cycle(1, 32'h99, 1, 32'h88, 1, 0);
    checks++; if ({got_a, got_b} !== 2'b10) begin errors++; $display("FAIL mid_restart got=%b exp=10", {got_a, got_b}); end
  endtask

  task automatic test_drain();
    cycle(0, 0, 1, 32'h5A5A, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    checks++; if (bif.out_valid !== 1'b1 || bif.out_data !== 32'h5A5A) begin errors++; $display("FAIL drain_hold got=%b/%h exp=1/5a5a", bif.out_valid, bif.out_data); end
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if ({got_a, got_b} !== 2'b00) begin errors++; $display("FAIL drain_ack got=%b exp=00", {got_a, got_b}); end
    checks++; if (bif.out_valid !== 1'b0 || bif.out_data !== 32'h5A5A || bif.out_owner !== 1'b1) begin errors++; $display("FAIL drain_out got=%b/%h/%b exp=0/5a5a/1", bif.out_valid, bif.out_data, bif.out_owner); end
    cycle(0, 0, 0, 0, 0, 0);
    checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL drain_idle got=%b exp=0", bif.out_valid); end
  endtask

  task automatic test_random();
    logic ra = 0, rb = 0, rdy, r;
    logic [31:0] da = 0, db = 0;
    int wait_a = 0, wait_b = 0;
    for (int i = 0; i < 400; i++) begin
      if (!ra || exp_a) begin ra = 1'($urandom_range(0, 1)); da = $urandom; end
      else if ($urandom_range(0, 15) == 0) ra = 0;
      if (!rb || exp_b) begin rb = 1'($urandom_range(0, 1)); db = $urandom; end
      else if ($urandom_range(0, 15) == 0) rb = 0;
      rdy = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 39) == 0;
      cycle(ra, da, rb, db, rdy, r);
      checks++; if ({got_a, got_b} !== {exp_a, exp_b}) begin errors++; $display("FAIL rnd_ack[%0d] got=%b exp=%b", i, {got_a, got_b}, {exp_a, exp_b}); end
      checks++; if ({bif.out_valid, bif.out_owner, bif.out_data} !== {m_valid, m_owner, m_data}) begin errors++; $display("FAIL rnd_out[%0d] got=%b/%b/%h exp=%b/%b/%h", i, bif.out_valid, bif.out_owner, bif.out_data, m_valid, m_owner, m_data); end
      wait_a = (ra && rb && exp_b) ? wait_a + 1 : 0;
      wait_b = (ra && rb && exp_a) ? wait_b + 1 : 0;
      checks++; if (wait_a > 1 || wait_b > 1) begin errors++; $display("FAIL rnd_fair[%0d] got=%0d/%0d exp<=1", i, wait_a, wait_b); end
      if (exp_a) wait_a = 0;
      if (exp_b) wait_b = 0;
    end
  endtask

  initial begin
    bif.req_a = 0; bif.req_b = 0; bif.in_a = 0; bif.in_b = 0; bif.out_ready = 0;
    m_valid = 0; m_data = 0; m_owner = 0; m_pref = 0;
    exp_a = 0; exp_b = 0;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_lone_b();
    test_reset_mid();
    test_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
